// File: rtl/adc_avg.sv
// rtl/adc_avg.sv - per-channel 2^k block averager with threshold flag, downstream of the ADC SPI front end
module adc_avg #(
   parameter int CH_LOG2      = 3,
   parameter int DATA_BITS    = 10,
   parameter int AVG_MAX_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] adc_data,
   input  logic        adc_wr,
   input  logic [23:0] in_data,
   input  logic [3:0]  in_ctrl,
   input  logic        in_wr,
   output logic [23:0] out_data,
   output logic        out_wr
);

   localparam int NCH   = 1 << CH_LOG2;
   localparam int ACC_W = DATA_BITS + AVG_MAX_LOG2;
   localparam int CNT_W = AVG_MAX_LOG2 + 1;
   localparam int SH_W  = (AVG_MAX_LOG2 < 1) ? 1 : $clog2(AVG_MAX_LOG2 + 1);
   localparam int PAD_W = 24 - 8 - 1 - DATA_BITS;
   localparam logic [3:0]           CFG_CODE = 4'd10;
   localparam logic [DATA_BITS-1:0] SAT      = '1;

   logic [ACC_W-1:0]     sum_q [NCH];
   logic [CNT_W-1:0]     cnt_q [NCH];
   logic                 enable_q;
   logic [SH_W-1:0]      shift_q;
   logic [DATA_BITS-1:0] thr_q;

   logic                 cfg_wr;
   logic [CH_LOG2-1:0]   ch;
   logic [DATA_BITS-1:0] sample;
   logic [ACC_W-1:0]     nsum;
   logic [CNT_W-1:0]     ncnt;
   logic [CNT_W-1:0]     target;
   logic                 blk_done;
   logic [ACC_W:0]       half;
   logic [ACC_W:0]       rnd;
   logic [ACC_W:0]       avg_full;
   logic [DATA_BITS-1:0] avg;
   logic [SH_W-1:0]      shift_cfg;
   logic                 unused_bits;

   assign cfg_wr      = in_wr && (in_ctrl == CFG_CODE);
   assign unused_bits = ^{in_data, adc_data};

   // Rounding add is one bit wider than the accumulator so it cannot wrap.
   always_comb begin
      ch        = adc_data[16 +: CH_LOG2];
      sample    = adc_data[DATA_BITS-1:0];
      nsum      = sum_q[ch] + ACC_W'(sample);
      ncnt      = cnt_q[ch] + CNT_W'(1);
      target    = CNT_W'(1) << shift_q;
      blk_done  = (ncnt == target);
      half      = (shift_q == '0) ? '0 : ((ACC_W+1)'(1) << (shift_q - SH_W'(1)));
      rnd       = {1'b0, nsum} + half;
      avg_full  = rnd >> shift_q;
      avg       = (avg_full > (ACC_W+1)'(SAT)) ? SAT : avg_full[DATA_BITS-1:0];
      shift_cfg = (in_data[3:0] > 4'(AVG_MAX_LOG2)) ? SH_W'(AVG_MAX_LOG2) : SH_W'(in_data[3:0]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_wr   <= 1'b0;
         out_data <= '0;
         enable_q <= 1'b0;
         shift_q  <= '0;
         thr_q    <= '1;
         for (int i = 0; i < NCH; i++) begin
            sum_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         out_wr <= 1'b0;
         if (cfg_wr) begin
            // A colliding sample is dropped: the config write owns this cycle.
            enable_q <= in_data[4];
            shift_q  <= shift_cfg;
            thr_q    <= in_data[12 +: DATA_BITS];
            for (int i = 0; i < NCH; i++) begin
               sum_q[i] <= '0;
               cnt_q[i] <= '0;
            end
         end else if (adc_wr) begin
            if (!enable_q) begin
               out_wr   <= 1'b1;
               out_data <= {adc_data[23:16], {PAD_W{1'b0}}, (sample >= thr_q), sample};
            end else if (blk_done) begin
               out_wr    <= 1'b1;
               out_data  <= {adc_data[23:16], {PAD_W{1'b0}}, (avg >= thr_q), avg};
               sum_q[ch] <= '0;
               cnt_q[ch] <= '0;
            end else begin
               sum_q[ch] <= nsum;
               cnt_q[ch] <= ncnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_avg.sv
// tb/tb_adc_avg.sv - directed and randomized check of adc_avg against a sample-queue reference model
module tb_adc_avg;

   logic        clk;
   logic        rst_n;
   logic [23:0] adc_data;
   logic        adc_wr;
   logic [23:0] in_data;
   logic [3:0]  in_ctrl;
   logic        in_wr;
   logic [23:0] out_data;
   logic        out_wr;

   adc_avg dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .adc_data (adc_data),
      .adc_wr   (adc_wr),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .in_wr    (in_wr),
      .out_data (out_data),
      .out_wr   (out_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;

   // Reference model: raw samples queued per channel, averaged when the block fills.
   bit          m_en;
   int          m_shift;
   int          m_thr;
   int          qs[8][$];
   logic [23:0] m_data;
   logic        m_wr;
   logic [23:0] outs[$];

   task automatic model_clear();
      for (int c = 0; c < 8; c++) qs[c].delete();
   endtask

   task automatic model(input logic r, input logic aw, input logic [23:0] ad,
                        input logic iw, input logic [3:0] ic, input logic [23:0] id);
      int ch, s, sum, avg;
      m_wr = 1'b0;
      if (!r) begin
         m_en = 0; m_shift = 0; m_thr = 1023; m_data = '0;
         model_clear();
      end else if (iw && ic == 4'd10) begin
         m_en    = id[4];
         m_shift = (id[3:0] > 4) ? 4 : int'(id[3:0]);
         m_thr   = int'(id[21:12]);
         model_clear();
      end else if (aw) begin
         ch = int'(ad[18:16]);
         s  = int'(ad[9:0]);
         if (!m_en) begin
            m_wr   = 1'b1;
            m_data = {ad[23:16], 5'b0, (s >= m_thr), 10'(s)};
         end else begin
            qs[ch].push_back(s);
            if (qs[ch].size() == (1 << m_shift)) begin
               sum = 0;
               foreach (qs[ch][i]) sum += qs[ch][i];
               avg = (sum + ((m_shift > 0) ? (1 << (m_shift - 1)) : 0)) >> m_shift;
               if (avg > 1023) avg = 1023;
               m_wr   = 1'b1;
               m_data = {ad[23:16], 5'b0, (avg >= m_thr), 10'(avg)};
               qs[ch].delete();
            end
         end
      end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clock: drive inputs away from the edge, advance, then compare 1 ns after the edge.
   task automatic step(input logic r, input logic aw, input logic [23:0] ad,
                       input logic iw, input logic [3:0] ic, input logic [23:0] id);
      rst_n = r; adc_wr = aw; adc_data = ad; in_wr = iw; in_ctrl = ic; in_data = id;
      model(r, aw, ad, iw, ic, id);
      @(posedge clk);
      #1;
      n_cmp++;
      assert (out_wr === m_wr) else begin
         n_err++;
         $error("FAIL out_wr observed=%b expected=%b", out_wr, m_wr);
      end
      n_cmp++;
      assert (out_data === m_data) else begin
         n_err++;
         $error("FAIL out_data observed=%06h expected=%06h", out_data, m_data);
      end
      if (out_wr === 1'b1) outs.push_back(out_data);
   endtask

   task automatic smp(input logic [7:0] addr, input int s);
      step(1'b1, 1'b1, {addr, 6'b0, 10'(s)}, 1'b0, 4'd0, 24'd0);
   endtask

   task automatic cfg(input logic [23:0] id);
      step(1'b1, 1'b0, 24'd0, 1'b1, 4'd10, id);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 24'd0, 1'b0, 4'd0, 24'd0);
   endtask

   task automatic rst(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'd0, 1'b0, 4'd0, 24'd0);
   endtask

   initial begin
      logic [7:0]  ra;
      logic [23:0] rd;
      int          act;
      rst_n = 1'b0; adc_wr = 1'b0; adc_data = '0; in_wr = 1'b0; in_ctrl = '0; in_data = '0;
      #2;

      rst(2);
      chk("reset_out_data", int'(out_data), 0);

      outs.delete();
      smp(8'h12, 10'h055);
      smp(8'hA3, 10'h200);
      smp(8'h07, 10'h3FF);
      idle(2);
      chk("bypass_count", outs.size(), 3);
      chk("bypass_thr0", int'(outs[0][10]), 0);
      chk("bypass_thr2", int'(outs[2][10]), 1);
      chk("bypass_echo1", int'(outs[1]), 24'hA30200);

      cfg(24'h000012);
      outs.delete();
      smp(8'h01, 100);
      smp(8'h41, 101);
      smp(8'h81, 102);
      smp(8'hC1, 104);
      idle(2);
      chk("avg4_count", outs.size(), 1);
      chk("avg4_value", int'(outs[0][9:0]), 102);
      chk("avg4_addr", int'(outs[0][23:16]), 8'hC1);

      cfg(24'h3FF011);
      outs.delete();
      smp(8'h00, 10);
      smp(8'h05, 1000);
      smp(8'h00, 11);
      smp(8'h05, 1023);
      idle(1);
      chk("ilv_count", outs.size(), 2);
      chk("ilv_ch0", int'(outs[0][9:0]), 11);
      chk("ilv_ch5", int'(outs[1][9:0]), 1012);

      cfg(24'h1F4014);
      outs.delete();
      for (int i = 0; i < 16; i++) smp(8'h07, 1023);
      idle(1);
      chk("sat_count", outs.size(), 1);
      chk("sat_value", int'(outs[0][9:0]), 1023);
      chk("sat_thr", int'(outs[0][10]), 1);

      cfg(24'h000011);
      outs.delete();
      smp(8'h02, 300);
      step(1'b1, 1'b1, {8'h02, 6'b0, 10'd900}, 1'b1, 4'd10, 24'h000011);
      chk("collide_none", outs.size(), 0);
      smp(8'h02, 20);
      smp(8'h02, 31);
      idle(1);
      chk("collide_count", outs.size(), 1);
      chk("collide_value", int'(outs[0][9:0]), 26);

      cfg(24'h000019);
      outs.delete();
      for (int i = 0; i < 8; i++) smp(8'h03, 1000);
      chk("clamp_partial", outs.size(), 0);
      rst(1);
      cfg(24'h000019);
      for (int i = 0; i < 15; i++) smp(8'h03, 50 * i);
      chk("clamp_15", outs.size(), 0);
      smp(8'h03, 750);
      idle(1);
      chk("clamp_count", outs.size(), 1);
      chk("clamp_value", int'(outs[0][9:0]), 375);

      for (int blk = 0; blk < 40; blk++) begin
         rd = {$urandom_range(0, 3) > 0 ? 2'b00 : 2'b11, 10'($urandom), 7'($urandom),
               1'($urandom_range(0, 4) > 0), 4'($urandom_range(0, 3) > 0 ? $urandom_range(0, 5) : $urandom_range(0, 15))};
         cfg(rd);
         for (int i = 0; i < 60; i++) begin
            act = $urandom_range(0, 99);
            ra  = 8'($urandom);
            rd  = {ra, 6'b0, ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom)};
            if (act < 65)      step(1'b1, 1'b1, rd, 1'b0, 4'd0, 24'd0);
            else if (act < 68) step(1'b1, 1'b1, rd, 1'b1, 4'd10, {2'b0, 10'($urandom), 7'd0, 1'b1, 4'($urandom_range(0, 5))});
            else if (act < 76) step(1'b1, 1'b1, rd, 1'b1, 4'($urandom_range(0, 9)), 24'($urandom));
            else if (act < 77) rst(1);
            else               idle(1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
